// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
//
// Purpose: executes MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO beside the
// EX-stage ALU. Multiplies use a shift-add loop and divides a restoring
// shift-subtract loop, one iteration per clock, on operand magnitudes. The sign
// is fixed up in a final cycle that also writes HI/LO.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   Start      in   issue strobe for Op, taken only while Busy=0
//   Op[2:0]    in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                   100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
//   A[31:0]    in   rs operand (multiplicand / dividend / MTHI-MTLO source)
//   B[31:0]    in   rt operand (multiplier / divisor)
//   Abort      in   pipeline flush, cancels any in-flight operation
//   Busy       out  operation in progress (stall request)
//   Done       out  one-cycle pulse when an operation retires
//   DivByZero  out  one-cycle pulse with Done for a divide by zero
//   Hi[31:0]   out  HI register
//   Lo[31:0]   out  LO register
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
  localparam int CW = $clog2(ITER) + 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic             neg_q;    // product / quotient is negative
  logic             rneg_q;   // remainder is negative (dividend sign)
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q; // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo_q; // multiplier bits shifting out / quotient bits shifting in
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  logic             signed_in, is_div_in, is_div_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] acc_hi_d, acc_lo_d;
  logic [2*WIDTH-1:0] prod_mag, prod_s, hilo, res;
  logic [WIDTH-1:0] fin_hi_d, fin_lo_d;

  always_comb begin
    signed_in = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    is_div_in = (Op == OP_DIV) || (Op == OP_DIVU);
    a_neg     = signed_in && A[WIDTH-1];
    b_neg     = signed_in && B[WIDTH-1];
    // 0x80000000 negates to itself, which is its correct unsigned magnitude
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;

    is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Partial remainder stays below the divisor, so the shifted value fits in
    // WIDTH+1 bits and the difference (when taken) fits back in WIDTH bits.
    div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_sh >= {1'b0, opnd_q};
    div_diff  = div_sh[WIDTH-1:0] - opnd_q;

    if (is_div_q) begin
      acc_hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_hi_d = mul_sum[WIDTH:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    prod_mag = {acc_hi_q, acc_lo_q};
    prod_s   = neg_q ? -prod_mag : prod_mag;
    hilo     = {hi_q, lo_q};
    case (op_q)
      OP_MADD: res = hilo + prod_s;
      OP_MSUB: res = hilo - prod_s;
      OP_DIV, OP_DIVU:
        res = {(rneg_q ? -acc_hi_q : acc_hi_q), (neg_q ? -acc_lo_q : acc_lo_q)};
      default: res = prod_s;
    endcase
    fin_hi_d = res[2*WIDTH-1:WIDTH];
    fin_lo_d = res[WIDTH-1:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (Abort) begin
        // Flush beats everything, including a same-cycle issue or the FIN write
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (Start) begin
              case (Op)
                OP_MTHI: hi_q <= A;
                OP_MTLO: lo_q <= A;
                default: begin
                  if (is_div_in && (B == '0)) begin
                    done_q <= 1'b1;
                    dbz_q  <= 1'b1;
                  end else begin
                    op_q     <= Op;
                    neg_q    <= a_neg ^ b_neg;
                    rneg_q   <= a_neg;
                    opnd_q   <= is_div_in ? b_mag : a_mag;
                    acc_hi_q <= '0;
                    acc_lo_q <= is_div_in ? a_mag : b_mag;
                    cnt_q    <= '0;
                    state_q  <= S_RUN;
                  end
                end
              endcase
            end
          end
          S_RUN: begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) state_q <= S_FIN;
          end
          S_FIN: begin
            hi_q    <= fin_hi_d;
            lo_q    <= fin_lo_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard testbench for mult_div_unit
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        abort;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int checks = 0;
  int fails  = 0;
  logic [64:0] exp_q[$];   // {DivByZero, Hi, Lo}

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .Op(op), .A(a), .B(b), .Abort(abort),
    .Busy(busy), .Done(done), .DivByZero(dbz), .Hi(hi), .Lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got dbz=%b hi=%h lo=%h expected no Done", dbz, hi, lo);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("done_result", {dbz, hi, lo}, e);
        check("busy_with_done", {64'd0, busy}, 65'd0);
      end
    end else if (rst_n && dbz) begin
      check("dbz_without_done", {64'd0, dbz}, 65'd0);
    end
  end

  // Issue one op and count Busy cycles; optionally inject a Start or an Abort
  // at a given busy cycle (0 = never).
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_busy, input int inject_at,
                        input int abort_at, input logic push, input logic [64:0] expv);
    int cnt;
    if (push) exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      if (cnt == inject_at) begin
        start = 1'b1; op = 3'b010; a = 32'd5; b = 32'd0;
      end
      if (cnt == abort_at) abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
    end
    check({name, "_busy_cycles"}, 65'(cnt), 65'(exp_busy));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_flags", {62'd0, busy, done, dbz}, 65'd0);
    check("reset_hilo", {1'b0, hi, lo}, 65'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult",  3'b000, 32'hFFFFFFFD, 32'd7, 33, 0, 0, 1, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op("multu", 3'b001, 32'hFFFFFFFD, 32'd7, 33, 0, 0, 1, {1'b0, 32'h00000006, 32'hFFFFFFEB});
    run_op("divu",  3'b011, 32'd100,      32'd7, 33, 0, 0, 1, {1'b0, 32'd2, 32'd14});
    run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 33, 0, 0, 1, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 33, 0, 0, 1, {1'b0, 32'd0, 32'h80000000});
    run_op("div_zero", 3'b010, 32'd5, 32'd0, 0, 0, 0, 1, {1'b1, 32'd0, 32'h80000000});

    run_op("mthi", 3'b100, 32'd0,  32'd0, 0, 0, 0, 0, '0);
    check("mthi_hi", {33'd0, hi}, 65'd0);
    run_op("mtlo", 3'b101, 32'd10, 32'd0, 0, 0, 0, 0, '0);
    check("mtlo_hilo", {1'b0, hi, lo}, {1'b0, 32'd0, 32'd10});
    run_op("madd", 3'b110, 32'd4, 32'd5, 33, 0, 0, 1, {1'b0, 32'd0, 32'd30});
    run_op("msub", 3'b111, 32'h80000000, 32'd2, 33, 0, 0, 1, {1'b0, 32'd1, 32'd30});

    // Start of a divide-by-zero while busy must be ignored entirely
    run_op("mult_inject", 3'b000, 32'd1000, 32'hFFFFFFFE, 33, 5, 0, 1,
           {1'b0, 32'hFFFFFFFF, 32'hFFFFF830});
    run_op("mult_abort", 3'b000, 32'd3, 32'd3, 10, 0, 10, 0, '0);
    check("abort_hilo", {1'b0, hi, lo}, {1'b0, 32'hFFFFFFFF, 32'hFFFFF830});
    run_op("mult_abort_fin", 3'b000, 32'd2, 32'd2, 33, 0, 33, 0, '0);
    check("abort_fin_hilo", {1'b0, hi, lo}, {1'b0, 32'hFFFFFFFF, 32'hFFFFF830});

    // Abort together with an MTHI in IDLE: nothing is issued
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_mthi", {32'd0, busy, hi}, {33'd0, 32'hFFFFFFFF});

    // Asynchronous reset between edges in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_flags", {62'd0, busy, done, dbz}, 65'd0);
    check("async_reset_hilo", {1'b0, hi, lo}, 65'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("divu_after_reset", 3'b011, 32'd9, 32'd3, 33, 0, 0, 1, {1'b0, 32'd0, 32'd3});

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 65'(exp_q.size()), 65'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the 32-bit ALU.
- Takes the same ID/EX operands A/B and holds the architectural HI/LO registers.
- Serves MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO.
- Busy is the stall request to the hazard unit; the Hi/Lo outputs feed the EX result mux for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand, HI and LO width; only 32 is supported.
- ITER, 32: iteration count for the shift-add multiply and restoring divide; must equal WIDTH.

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  issue strobe for Op; accepted only when Busy=0
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
- A  input  32  rs operand (multiplicand/dividend; source for MTHI/MTLO)
- B  input  32  rt operand (multiplier/divisor)
- Abort  input  1  pipeline flush; cancels any in-flight operation
- Busy  output  1  operation in progress; stall request
- Done  output  1  one-cycle pulse when a multi-cycle op retires
- DivByZero  output  1  one-cycle pulse with Done for DIV/DIVU when B=0
- Hi  output  32  HI register
- Lo  output  32  LO register

Behaviour:
- Reset (Reset=0, asynchronous):
  - Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0.
  - State=IDLE, iteration counter=0, all internal datapath registers cleared.
  - Asserting Reset mid-operation kills the operation with no partial Hi/Lo write.
- States: IDLE, RUN, FIN.
- IDLE, Start=1 at edge N:
  - MTHI/MTLO: Hi (or Lo) <= A at edge N. Stay IDLE; no Busy, no Done.
  - DIV/DIVU with B=0: stay IDLE; Done=1 and DivByZero=1 for the cycle after edge N; Hi/Lo unchanged.
  - Any other op: latch operand magnitudes, sign flags and Op; counter=0; state=RUN; Busy=1 from edge N.
- RUN:
  - One iteration per edge (multiply: shift-add; divide: restoring shift-subtract).
  - Counter increments each edge; after edge N+ITER the state is FIN.
- FIN, edge N+ITER+1:
  - Apply sign correction and write Hi/Lo.
  - Busy=0, Done=1 for exactly one cycle, state=IDLE.
  - Start-to-Done latency is ITER+1 = 33 edges.
- Arithmetic results:
  - MULT/MULTU: {Hi,Lo} = 64-bit signed/unsigned product.
  - MADD/MSUB: {Hi,Lo} = {Hi,Lo} +/- signed 64-bit product. Uses the Hi/Lo values present at FIN; wraps modulo 2^64.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives Lo=0x80000000, Hi=0, with no flag.
- Start while Busy=1: ignored, no queueing. The hazard unit must hold the instruction.
- Abort:
  - Any state: next edge forces IDLE, Busy=0, Done=0; Hi/Lo unchanged.
  - Abort and Start in the same IDLE cycle: Abort wins and nothing is issued, including MTHI/MTLO.
  - Abort in FIN: suppresses both the Hi/Lo write and Done.
- Hi/Lo change only at reset, on MTHI/MTLO, or at FIN.
- Done and DivByZero are never asserted in the same cycle as Busy.

Test Plan:
- Reset release, MULT A=0xFFFFFFFD (-3), B=7 -> Busy=1 for 33 cycles, then Done pulse with Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. MULTU on the same operands -> Hi=0x00000006, Lo=0xFFFFFFEB.
- DIVU A=100, B=7 -> Lo=14, Hi=2. DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIV A=5, B=0 -> Done=1 and DivByZero=1 on the next cycle, Busy never asserted, Hi/Lo keep their prior values.
- MTHI A=0, MTLO A=10, then MADD A=4, B=5 -> Hi=0, Lo=30. MSUB A=0x80000000, B=2 -> {Hi,Lo} = 30 + 2^32 = Hi=1, Lo=30.
- During MULT, Start a DIV at cycle 5 -> ignored, and the MULT result is correct at cycle 33. Abort at cycle 10 of a second MULT -> Busy drops next edge, no Done, Hi/Lo unchanged.
- Reset driven low asynchronously mid-DIV (between edges) -> all outputs 0 immediately. After release, DIVU 9/3 -> Lo=3, Hi=0 after 33 cycles.
